tp_mem_copy_ctrl_1024_32: RTL

TP_MEM_COPY_CTRL_1024_32 -- requirements
Module: tp_mem_copy_ctrl_1024_32

---
 rtl/tp_mem_copy_ctrl_1024_32.sv | 134 +++++++++++++
 1 files changed

// File: rtl/tp_mem_copy_ctrl_1024_32.sv
// Word COPY/FILL engine for a 1024x32 two-port RAM: port A reads source words,
// port B writes destination words, one word per cycle in ascending address order.
module tp_mem_copy_ctrl_1024_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [9:0]  src_addr,
  input  logic [9:0]  dst_addr,
  input  logic [10:0] len,
  input  logic [31:0] fill_data,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [10:0] words_done,
  output logic        mem_wen_a,
  output logic [9:0]  mem_addr_a,
  output logic [31:0] mem_din_a,
  input  logic [31:0] mem_dout_a,
  output logic        mem_wen_b,
  output logic [9:0]  mem_addr_b,
  output logic [31:0] mem_din_b
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]  r_state;
  logic        r_op;
  logic [9:0]  r_src;
  logic [9:0]  r_dst;
  logic [10:0] r_len;
  logic [10:0] r_k;
  logic [10:0] r_words_done;
  logic [31:0] r_fill;
  logic        r_aborted;

  logic        w_run;
  logic        w_drain;
  logic        w_last;
  logic        w_wen_b;
  logic [9:0]  w_addr_a;
  logic [9:0]  w_addr_b;
  logic [31:0] w_din_b;

  // COPY writes lag reads by one cycle (registered RAM read); DRAIN sees r_k == len,
  // so the same dst + k - 1 expression covers the final write.
  always_comb begin
    w_run    = (r_state == StRun);
    w_drain  = (r_state == StDrain);
    w_last   = (r_k == r_len - 11'd1);
    w_wen_b  = 1'b0;
    w_addr_a = 10'd0;
    w_addr_b = 10'd0;
    w_din_b  = 32'd0;
    if (w_run && !r_op) begin
      w_addr_a = r_src + r_k[9:0];
    end
    if (w_run && r_op) begin
      w_wen_b  = 1'b1;
      w_addr_b = r_dst + r_k[9:0];
      w_din_b  = r_fill;
    end else if ((w_run && (r_k != 11'd0)) || w_drain) begin
      w_wen_b  = 1'b1;
      w_addr_b = r_dst + r_k[9:0] - 10'd1;
      w_din_b  = mem_dout_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_op         <= 1'b0;
      r_src        <= 10'd0;
      r_dst        <= 10'd0;
      r_len        <= 11'd0;
      r_k          <= 11'd0;
      r_words_done <= 11'd0;
      r_fill       <= 32'd0;
      r_aborted    <= 1'b0;
    end else begin
      if (w_wen_b) begin
        r_words_done <= r_words_done + 11'd1;
      end
      case (r_state)
        StIdle: begin
          if (start) begin
            r_op         <= op;
            r_src        <= src_addr;
            r_dst        <= dst_addr;
            r_len        <= len;
            r_fill       <= fill_data;
            r_k          <= 11'd0;
            r_words_done <= 11'd0;
            r_aborted    <= 1'b0;
            r_state      <= (len == 11'd0) ? StDone : StRun;
          end
        end
        StRun: begin
          r_k <= r_k + 11'd1;
          if (abort) begin
            r_state   <= StDone;
            r_aborted <= 1'b1;
          end else if (w_last) begin
            r_state <= r_op ? StDone : StDrain;
          end
        end
        StDrain: begin
          r_state <= StDone;
          if (abort) begin
            r_aborted <= 1'b1;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy       = w_run || w_drain;
  assign done       = (r_state == StDone);
  assign aborted    = r_aborted;
  assign words_done = r_words_done;
  assign mem_wen_a  = 1'b0;
  assign mem_addr_a = w_addr_a;
  assign mem_din_a  = 32'd0;
  assign mem_wen_b  = w_wen_b;
  assign mem_addr_b = w_addr_b;
  assign mem_din_b  = w_din_b;

endmodule
